lc3b_pc_control: RTL and testbench
==================================

LC3B_PC_CONTROL -- requirements
Module: lc3b_pc_control

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port opcode  input  lc3b_opcode (4)  IR[15:12], valid from DECODE onward.
REQ-004 SHALL have port ir11  input  1  IR[11], JSR/JSRR select.
REQ-005 SHALL have port ir_nzp  input  3  IR[11:9], branch condition mask.
REQ-006 SHALL have port cc  input  3  current n/z/p condition codes.
REQ-007 SHALL have port mem_resp  input  1  memory completion strobe.
REQ-008 SHALL have port exec_done  input  1  execute-unit completion strobe.
REQ-009 SHALL have port load_mar  output  1  load MAR.
REQ-010 SHALL have port load_ir  output  1  load IR.
REQ-011 SHALL have port load_pc  output  1  load PC register.
REQ-012 SHALL have port pcmux_sel  output  lc3b_sel (2)  00 pc+2, 01 pc+offset, 10 alu_out, 11 mem_wdata.
REQ-013 SHALL have port offsetmux_sel  output  1  0 adj9, 1 adj11.
REQ-014 SHALL have port mem_read  output  1  memory read request.
REQ-015 SHALL have port load_r7  output  1  write link (pc) to R7.
REQ-016 SHALL have port exec_req  output  1  hand non-control instruction to execute unit.
REQ-017 SHALL have port timeout_err  output  1  sticky memory-timeout flag.

Function
REQ-018 SHALL be a Moore FSM with states IDLE, FETCH1, FETCH2, FETCH3, DECODE, BR_TAKEN, JMP, JSR, TRAP1, TRAP2, TRAP3, EXEC, ERR; all outputs 0 except where listed.
REQ-019 SHALL go IDLE -> FETCH1 unconditionally in the first clock edge after reset release.
REQ-020 SHALL in FETCH1 assert load_mar, load_pc, pcmux_sel=00, then go to FETCH2.
REQ-021 SHALL in FETCH2 assert mem_read, remain until mem_resp=1, then go to FETCH3.
REQ-022 SHALL in FETCH3 assert load_ir, then go to DECODE.
REQ-023 SHALL in DECODE branch: BR (0000) to BR_TAKEN if (ir_nzp & cc)!=0, else FETCH1; JMP (1100) to JMP; JSR (0100) to JSR; TRAP (1111) to TRAP1; all others to EXEC.
REQ-024 SHALL in BR_TAKEN assert load_pc, pcmux_sel=01, offsetmux_sel=0, then go to FETCH1.
REQ-025 SHALL in JMP assert load_pc, pcmux_sel=10, then go to FETCH1.
REQ-026 SHALL in JSR assert load_r7, load_pc; ir11=1: pcmux_sel=01, offsetmux_sel=1; ir11=0: pcmux_sel=10; then go to FETCH1.
REQ-027 SHALL in TRAP1 assert load_r7, load_mar; TRAP2 as FETCH2 (mem_read until mem_resp); TRAP3 assert load_pc, pcmux_sel=11; then go to FETCH1.
REQ-028 SHALL in EXEC assert exec_req, hold until exec_done=1, then go to FETCH1; exec_done outside EXEC SHALL be ignored.
REQ-029 SHALL ignore mem_resp in any state other than FETCH2/TRAP2.
REQ-030 SHALL require fetch-to-fetch latency of exactly 4 cycles for a not-taken BR with mem_resp on the first FETCH2 cycle.

Reset
REQ-031 SHALL, on rst_n=0 at any time (including mid-fetch or mid-TRAP), immediately enter IDLE with every output 0 and the timeout counter cleared.
REQ-032 SHALL clear timeout_err only by reset.

Configuration
REQ-033 SHALL, with FETCH_TIMEOUT_EN defined, count cycles spent in FETCH2/TRAP2 with an 8-bit counter cleared on state entry; when the count reaches 255 and mem_resp=0, go to ERR; mem_resp=1 in that same cycle SHALL win.
REQ-034 SHALL, in ERR, drive timeout_err=1 and all other outputs 0, and remain there until reset.
REQ-035 SHALL, without FETCH_TIMEOUT_EN, wait indefinitely in FETCH2/TRAP2, omit the counter and ERR, and tie timeout_err to 0.

Verification
REQ-036 SHALL cover: opcode=0001, mem_resp on the 1st FETCH2 cycle, exec_done 2 cycles later -> load_mar/load_pc(sel 00) pulse, load_ir pulse, exec_req high 3 cycles, then back in FETCH1.
REQ-037 SHALL cover: BR, ir_nzp=010, cc=010 -> BR_TAKEN with load_pc=1, pcmux_sel=01, offsetmux_sel=0; with cc=100 -> no load_pc, direct return to FETCH1.
REQ-038 SHALL cover: JSR ir11=1 -> load_r7=1, pcmux_sel=01, offsetmux_sel=1; JSRR ir11=0 -> pcmux_sel=10.
REQ-039 SHALL cover: TRAP with mem_resp delayed 5 cycles -> mem_read held 6 cycles in TRAP2, then TRAP3 pcmux_sel=11 with load_pc=1.
REQ-040 SHALL cover: FETCH_TIMEOUT_EN, mem_resp never asserted -> ERR after 256 FETCH2 cycles, timeout_err=1 sticky; mem_resp at count 255 -> FETCH3, no error.
REQ-041 SHALL cover: rst_n pulsed low during TRAP2 -> all outputs 0 asynchronously, IDLE then FETCH1 after release.

Source files
------------

// File: rtl/lc3b_pc_control.sv
// ---------------------------------------------------------------------------
// lc3b_pc_control
//
// Moore FSM sequencing instruction fetch and the PC-changing instructions
// (BR, JMP, JSR/JSRR, TRAP) of an LC-3b style core. Every other opcode is
// handed to an external execute unit, and the FSM waits for it to finish.
//
// Ports
//   clk            rising-edge clock, sole clock domain
//   rst_n          asynchronous active-low reset
//   opcode[3:0]    IR[15:12], valid from DECODE onward
//   ir11           IR[11], selects JSR (1) or JSRR (0)
//   ir_nzp[2:0]    IR[11:9], branch condition mask
//   cc[2:0]        current n/z/p condition codes
//   mem_resp       memory completion strobe (only seen in FETCH2/TRAP2)
//   exec_done      execute-unit completion strobe (only seen in EXEC)
//   load_mar       load MAR
//   load_ir        load IR
//   load_pc        load PC
//   pcmux_sel[1:0] 00 pc+2, 01 pc+offset, 10 alu_out, 11 mem_wdata
//   offsetmux_sel  0 adj9, 1 adj11
//   mem_read       memory read request
//   load_r7        write link (pc) to R7
//   exec_req       hand instruction to execute unit
//   timeout_err    sticky memory-timeout flag
//
// Build option
//   FETCH_TIMEOUT_EN  When defined, an 8-bit counter measures time spent
//                     waiting in FETCH2/TRAP2; after 256 cycles with no
//                     mem_resp the FSM parks in ERR until reset. When not
//                     defined, memory waits are unbounded and timeout_err
//                     is tied low.
// ---------------------------------------------------------------------------
module lc3b_pc_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] opcode,
    input  logic       ir11,
    input  logic [2:0] ir_nzp,
    input  logic [2:0] cc,
    input  logic       mem_resp,
    input  logic       exec_done,
    output logic       load_mar,
    output logic       load_ir,
    output logic       load_pc,
    output logic [1:0] pcmux_sel,
    output logic       offsetmux_sel,
    output logic       mem_read,
    output logic       load_r7,
    output logic       exec_req,
    output logic       timeout_err
);

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    localparam logic [1:0] PC_PLUS2  = 2'b00;
    localparam logic [1:0] PC_OFFSET = 2'b01;
    localparam logic [1:0] PC_ALU    = 2'b10;
    localparam logic [1:0] PC_MDATA  = 2'b11;

    typedef enum logic [3:0] {
        IDLE,
        FETCH1,
        FETCH2,
        FETCH3,
        DECODE,
        BR_TAKEN,
        JMP,
        JSR,
        TRAP1,
        TRAP2,
        TRAP3,
        EXEC,
        ERR
    } state_t;

    state_t state_q, state_d;

`ifdef FETCH_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
`endif

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves it unassigned and no latch is inferred.
        state_d = state_q;

        unique case (state_q)
            IDLE:     state_d = FETCH1;
            FETCH1:   state_d = FETCH2;
            FETCH2: begin
                if (mem_resp) begin
                    state_d = FETCH3;
`ifdef FETCH_TIMEOUT_EN
                end else if (cnt_q == 8'hFF) begin
                    state_d = ERR;
`endif
                end
            end
            FETCH3:   state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_BR:   state_d = ((ir_nzp & cc) != 3'b000) ? BR_TAKEN : FETCH1;
                    OP_JMP:  state_d = JMP;
                    OP_JSR:  state_d = JSR;
                    OP_TRAP: state_d = TRAP1;
                    default: state_d = EXEC;
                endcase
            end
            BR_TAKEN: state_d = FETCH1;
            JMP:      state_d = FETCH1;
            JSR:      state_d = FETCH1;
            TRAP1:    state_d = TRAP2;
            TRAP2: begin
                if (mem_resp) begin
                    state_d = TRAP3;
`ifdef FETCH_TIMEOUT_EN
                end else if (cnt_q == 8'hFF) begin
                    state_d = ERR;
`endif
                end
            end
            TRAP3:    state_d = FETCH1;
            EXEC:     state_d = exec_done ? FETCH1 : EXEC;
`ifdef FETCH_TIMEOUT_EN
            ERR:      state_d = ERR;
`endif
            default:  state_d = IDLE;
        endcase
    end

`ifdef FETCH_TIMEOUT_EN
    // Counter reads 0 on the first cycle of a memory wait and increments
    // only while the FSM stays put, so count 255 marks the 256th cycle.
    always_comb begin
        cnt_d = 8'd0;
        if ((state_q == FETCH2 || state_q == TRAP2) && state_d == state_q) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge
        // values regardless of block ordering.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // Moore outputs: decoded from the current state only, so an async reset
    // forces them all low immediately via IDLE.
    // ---------------------------------------------------------------------
    always_comb begin
        load_mar      = 1'b0;
        load_ir       = 1'b0;
        load_pc       = 1'b0;
        pcmux_sel     = PC_PLUS2;
        offsetmux_sel = 1'b0;
        mem_read      = 1'b0;
        load_r7       = 1'b0;
        exec_req      = 1'b0;

        unique case (state_q)
            FETCH1: begin
                load_mar  = 1'b1;
                load_pc   = 1'b1;
                pcmux_sel = PC_PLUS2;
            end
            FETCH2:   mem_read = 1'b1;
            FETCH3:   load_ir  = 1'b1;
            BR_TAKEN: begin
                load_pc       = 1'b1;
                pcmux_sel     = PC_OFFSET;
                offsetmux_sel = 1'b0;
            end
            JMP: begin
                load_pc   = 1'b1;
                pcmux_sel = PC_ALU;
            end
            JSR: begin
                load_r7 = 1'b1;
                load_pc = 1'b1;
                if (ir11) begin
                    pcmux_sel     = PC_OFFSET;
                    offsetmux_sel = 1'b1;
                end else begin
                    pcmux_sel = PC_ALU;
                end
            end
            TRAP1: begin
                load_r7  = 1'b1;
                load_mar = 1'b1;
            end
            TRAP2:    mem_read = 1'b1;
            TRAP3: begin
                load_pc   = 1'b1;
                pcmux_sel = PC_MDATA;
            end
            EXEC:     exec_req = 1'b1;
            default: ;
        endcase
    end

`ifdef FETCH_TIMEOUT_EN
    assign timeout_err = (state_q == ERR);
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_lc3b_pc_control.sv
// ---------------------------------------------------------------------------
// tb_lc3b_pc_control
//
// Instruction-level reference model: each instruction is expanded into the
// per-cycle list of expected control words and the input values to drive in
// that cycle (memory/execute latencies, noise on strobes that must be
// ignored). The list is then played against the DUT one clock at a time.
// Define FETCH_TIMEOUT_EN for both bench and RTL to exercise the timeout.
// ---------------------------------------------------------------------------
module tb_lc3b_pc_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] opcode;
    logic       ir11;
    logic [2:0] ir_nzp;
    logic [2:0] cc;
    logic       mem_resp;
    logic       exec_done;
    logic       load_mar, load_ir, load_pc, offsetmux_sel;
    logic       mem_read, load_r7, exec_req, timeout_err;
    logic [1:0] pcmux_sel;

    lc3b_pc_control dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .ir11          (ir11),
        .ir_nzp        (ir_nzp),
        .cc            (cc),
        .mem_resp      (mem_resp),
        .exec_done     (exec_done),
        .load_mar      (load_mar),
        .load_ir       (load_ir),
        .load_pc       (load_pc),
        .pcmux_sel     (pcmux_sel),
        .offsetmux_sel (offsetmux_sel),
        .mem_read      (mem_read),
        .load_r7       (load_r7),
        .exec_req      (exec_req),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    // Control word: {load_mar, load_ir, load_pc, pcmux_sel[1:0],
    //                offsetmux_sel, mem_read, load_r7, exec_req, timeout_err}
    localparam logic [9:0] W_NONE = 10'b0;
    localparam logic [9:0] O_MAR  = 10'b1 << 9;
    localparam logic [9:0] O_IR   = 10'b1 << 8;
    localparam logic [9:0] O_PC   = 10'b1 << 7;
    localparam logic [9:0] SEL01  = 10'b1 << 5;
    localparam logic [9:0] SEL10  = 10'b1 << 6;
    localparam logic [9:0] SEL11  = (10'b1 << 6) | (10'b1 << 5);
    localparam logic [9:0] O_OFF  = 10'b1 << 4;
    localparam logic [9:0] O_RD   = 10'b1 << 3;
    localparam logic [9:0] O_R7   = 10'b1 << 2;
    localparam logic [9:0] O_EX   = 10'b1 << 1;
    localparam logic [9:0] O_TE   = 10'b1;

    typedef struct {
        logic       resp;
        logic       done;
        logic [3:0] op;
        logic       i11;
        logic [2:0] nzp;
        logic [2:0] ccv;
        logic [9:0] exp;
        string      tag;
    } step_t;

    step_t      steps[$];
    int         n_cmp  = 0;
    int         n_fail = 0;

    logic [3:0] cur_op;
    logic       cur_i11;
    logic [2:0] cur_nzp;
    logic [2:0] cur_cc;

    function automatic logic [9:0] obs();
        return {load_mar, load_ir, load_pc, pcmux_sel, offsetmux_sel,
                mem_read, load_r7, exec_req, timeout_err};
    endfunction

    function automatic logic noise();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check(input logic [9:0] got, input logic [9:0] want, input string tag);
        n_cmp++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, want);
        end
    endtask

    task automatic push(input logic [9:0] e, input logic r, input logic d, input string tag);
        step_t s;
        s.resp = r;
        s.done = d;
        s.op   = cur_op;
        s.i11  = cur_i11;
        s.nzp  = cur_nzp;
        s.ccv  = cur_cc;
        s.exp  = e;
        s.tag  = tag;
        steps.push_back(s);
    endtask

    // Memory wait of (lat+1) cycles, mem_resp on the last one.
    task automatic push_mem_wait(input int lat, input string tag);
        for (int i = 0; i <= lat; i++)
            push(O_RD, (i == lat), noise(), tag);
    endtask

    // Expand one instruction into its expected cycle sequence.
    task automatic build_instr(input logic [3:0] op, input logic i11, input logic [2:0] nzp,
                               input logic [2:0] ccv, input int fetch_lat, input int exec_lat,
                               input int trap_lat, input string tag);
        cur_op  = op;
        cur_i11 = i11;
        cur_nzp = nzp;
        cur_cc  = ccv;
        push(O_MAR | O_PC, noise(), noise(), {tag, " fetch1"});
        push_mem_wait(fetch_lat, {tag, " fetch2"});
        push(O_IR, noise(), noise(), {tag, " fetch3"});
        push(W_NONE, noise(), noise(), {tag, " decode"});
        if (op == 4'b0000) begin
            if ((nzp & ccv) != 3'b000)
                push(O_PC | SEL01, noise(), noise(), {tag, " br_taken"});
        end else if (op == 4'b1100) begin
            push(O_PC | SEL10, noise(), noise(), {tag, " jmp"});
        end else if (op == 4'b0100) begin
            push(O_R7 | O_PC | (i11 ? (SEL01 | O_OFF) : SEL10), noise(), noise(), {tag, " jsr"});
        end else if (op == 4'b1111) begin
            push(O_R7 | O_MAR, noise(), noise(), {tag, " trap1"});
            push_mem_wait(trap_lat, {tag, " trap2"});
            push(O_PC | SEL11, noise(), noise(), {tag, " trap3"});
        end else begin
            for (int i = 0; i <= exec_lat; i++)
                push(O_EX, noise(), (i == exec_lat), {tag, " exec"});
        end
    endtask

    // Play queued cycles: on each falling edge compare the control word of the
    // current cycle and drive the inputs that decide the next transition.
    task automatic run_steps();
        int idx = 0;
        while (steps.size() > 0) begin
            step_t s = steps.pop_front();
            @(negedge clk);
            check(obs(), s.exp, $sformatf("%s c%0d", s.tag, idx));
            mem_resp  = s.resp;
            exec_done = s.done;
            opcode    = s.op;
            ir11      = s.i11;
            ir_nzp    = s.nzp;
            cc        = s.ccv;
            idx++;
        end
    endtask

    // Asynchronous reset mid-cycle, outputs must drop before any clock edge.
    task automatic pulse_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 check(obs(), W_NONE, {tag, " async"});
        @(negedge clk);
        check(obs(), W_NONE, {tag, " held"});
        rst_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        opcode    = 4'b0;
        ir11      = 1'b0;
        ir_nzp    = 3'b0;
        cc        = 3'b0;
        mem_resp  = 1'b0;
        exec_done = 1'b0;

        // Reset state: all outputs low regardless of strobes.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_resp  = noise();
            exec_done = noise();
            check(obs(), W_NONE, "reset");
        end
        rst_n = 1'b1;

        // Directed instructions.
        build_instr(4'b0001, 1'b0, 3'b000, 3'b000, 0, 2, 0, "add");
        build_instr(4'b0000, 1'b0, 3'b010, 3'b010, 0, 0, 0, "br_t");
        build_instr(4'b0000, 1'b0, 3'b010, 3'b100, 0, 0, 0, "br_nt");
        build_instr(4'b0100, 1'b1, 3'b000, 3'b000, 1, 0, 0, "jsr");
        build_instr(4'b0100, 1'b0, 3'b000, 3'b000, 0, 0, 0, "jsrr");
        build_instr(4'b1100, 1'b0, 3'b000, 3'b000, 2, 0, 0, "jmp");
        build_instr(4'b1111, 1'b0, 3'b000, 3'b000, 0, 0, 5, "trap");
        build_instr(4'b0000, 1'b0, 3'b000, 3'b111, 0, 0, 0, "br_never");
        build_instr(4'b0000, 1'b0, 3'b111, 3'b001, 0, 0, 0, "br_always");
        run_steps();

        // Randomized instruction stream.
        for (int n = 0; n < 60; n++) begin
            logic [3:0] op;
            case ($urandom_range(0, 4))
                0:       op = 4'b0000;
                1:       op = 4'b1100;
                2:       op = 4'b0100;
                3:       op = 4'b1111;
                default: op = 4'($urandom_range(0, 15));
            endcase
            build_instr(op, noise(), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                        $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 6),
                        $sformatf("rnd%0d", n));
        end
        run_steps();

        // Reset in the middle of the TRAP memory wait.
        cur_op  = 4'b1111;
        cur_i11 = 1'b0;
        cur_nzp = 3'b000;
        cur_cc  = 3'b000;
        push(O_MAR | O_PC, 1'b0, 1'b0, "trap_rst fetch1");
        push(O_RD, 1'b1, 1'b0, "trap_rst fetch2");
        push(O_IR, 1'b0, 1'b0, "trap_rst fetch3");
        push(W_NONE, 1'b0, 1'b0, "trap_rst decode");
        push(O_R7 | O_MAR, 1'b0, 1'b0, "trap_rst trap1");
        for (int i = 0; i < 3; i++)
            push(O_RD, 1'b0, 1'b0, "trap_rst trap2");
        run_steps();
        pulse_reset("trap_rst");
        build_instr(4'b0001, 1'b0, 3'b000, 3'b000, 0, 0, 0, "post_rst");
        run_steps();

        // Memory that never answers.
        cur_op = 4'b0001;
        push(O_MAR | O_PC, noise(), noise(), "hang fetch1");
`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 256; i++)
            push(O_RD, 1'b0, noise(), "hang fetch2");
        for (int i = 0; i < 6; i++)
            push(O_TE, noise(), noise(), "hang err");
        run_steps();
        pulse_reset("err_rst");
        // Response on the last permitted cycle wins over the timeout.
        build_instr(4'b1100, 1'b0, 3'b000, 3'b000, 255, 0, 0, "late_fetch");
        build_instr(4'b1111, 1'b0, 3'b000, 3'b000, 0, 0, 255, "late_trap");
        run_steps();
`else
        for (int i = 0; i < 300; i++)
            push(O_RD, 1'b0, noise(), "hang fetch2");
        run_steps();
        pulse_reset("hang_rst");
        build_instr(4'b1100, 1'b0, 3'b000, 3'b000, 0, 0, 0, "post_hang");
        run_steps();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
